// File: rtl/branch_history_unit_pkg.sv
// Shared defaults and in-flight entry layout for the local branch history unit.
package branch_history_unit_pkg;

    localparam int unsigned REGSIZE_DEF = 2;
    localparam int unsigned IDXW_DEF    = 3;
    localparam int unsigned QDEPTH_DEF  = 4;

    typedef struct packed {
        logic [IDXW_DEF-1:0]    idx;
        logic [REGSIZE_DEF-1:0] pattern;
    } bhu_entry_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-flight branch FIFO: push/pop/clear with occupancy count; clear wins over a same-cycle push.
module branch_inflight_fifo
    import branch_history_unit_pkg::*;
#(
    parameter int unsigned DEPTH   = QDEPTH_DEF,
    parameter type         entry_t = bhu_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  entry_t        wdata_i,
    output entry_t        rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_history_unit.sv
// Local branch history table with in-flight snapshot queue and pattern-table update port.
module branch_history_unit
    import branch_history_unit_pkg::*;
#(
    parameter int unsigned REGSIZE = REGSIZE_DEF,
    parameter int unsigned IDXW    = IDXW_DEF,
    parameter int unsigned QDEPTH  = QDEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lk_valid,
    input  logic [31:0]                lk_pc,
    output logic                       lk_ready,
    output logic [REGSIZE-1:0]         lk_pattern,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       flush,
    output logic                       pht_en,
    output logic [REGSIZE-1:0]         pht_addr,
    output logic                       pht_pcbranch,
    output logic                       res_err,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int unsigned NENT = 1 << IDXW;
    localparam int unsigned CW   = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [IDXW-1:0]    idx;
        logic [REGSIZE-1:0] pattern;
    } entry_t;

    logic [REGSIZE-1:0] hist_q [NENT];
    logic [IDXW-1:0]    lk_idx;
    logic               full, empty, push, pop;
    entry_t             head, push_entry;
    logic [REGSIZE-1:0] hist_upd;
    logic [CW-1:0]      count;
    logic               pc_unused;

    logic               pht_en_q, pht_en_d;
    logic [REGSIZE-1:0] pht_addr_q, pht_addr_d;
    logic               pht_pcbranch_q, pht_pcbranch_d;
    logic               res_err_q, res_err_d;

    assign lk_idx    = lk_pc[IDXW+1:2];
    assign pc_unused = ^{lk_pc[31:IDXW+2], lk_pc[1:0]};
    assign lk_ready  = !full;
    assign push      = lk_valid && !full;
    assign pop       = res_valid && !empty;
    assign hist_upd  = REGSIZE'({hist_q[head.idx], res_taken});

    // Bypass the history write of a same-cycle resolve to the same entry.
    always_comb begin
        lk_pattern = hist_q[lk_idx];
        if (pop && (head.idx == lk_idx)) lk_pattern = hist_upd;
    end

    assign push_entry = '{idx: lk_idx, pattern: lk_pattern};

    branch_inflight_fifo #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        pht_en_d       = pop;
        pht_addr_d     = pht_addr_q;
        pht_pcbranch_d = pht_pcbranch_q;
        res_err_d      = res_valid && empty;
        if (pop) begin
            pht_addr_d     = head.pattern;
            pht_pcbranch_d = res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NENT); i++) hist_q[i] <= '0;
            pht_en_q       <= 1'b0;
            pht_addr_q     <= '0;
            pht_pcbranch_q <= 1'b0;
            res_err_q      <= 1'b0;
        end else begin
            if (pop) hist_q[head.idx] <= hist_upd;
            pht_en_q       <= pht_en_d;
            pht_addr_q     <= pht_addr_d;
            pht_pcbranch_q <= pht_pcbranch_d;
            res_err_q      <= res_err_d;
        end
    end

    assign pht_en       = pht_en_q;
    assign pht_addr     = pht_addr_q;
    assign pht_pcbranch = pht_pcbranch_q;
    assign res_err      = res_err_q;
    assign q_count      = count;

endmodule

// File: tb/tb_branch_history_unit.sv
// Directed and randomized checks of branch_history_unit against a behavioural model and PHT scoreboard.
module tb_branch_history_unit;

    localparam int unsigned RS = 2;
    localparam int unsigned IW = 3;
    localparam int unsigned QD = 4;

    logic          clk = 1'b0;
    logic          rst, lk_valid, res_valid, res_taken, flush;
    logic [31:0]   lk_pc;
    logic          lk_ready, pht_en, pht_pcbranch, res_err;
    logic [RS-1:0] lk_pattern, pht_addr;
    logic [2:0]    q_count;

    branch_history_unit #(.REGSIZE(RS), .IDXW(IW), .QDEPTH(QD)) dut (
        .clk          (clk),
        .rst          (rst),
        .lk_valid     (lk_valid),
        .lk_pc        (lk_pc),
        .lk_ready     (lk_ready),
        .lk_pattern   (lk_pattern),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .flush        (flush),
        .pht_en       (pht_en),
        .pht_addr     (pht_addr),
        .pht_pcbranch (pht_pcbranch),
        .res_err      (res_err),
        .q_count      (q_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [IW-1:0] idx; logic [RS-1:0] pat; } ent_t;
    typedef struct packed { logic [RS-1:0] addr; logic tk; } upd_t;

    int            checks = 0;
    int            errors = 0;
    logic [RS-1:0] mh [8];
    ent_t          mq [$];
    upd_t          sb [$];
    logic          m_pop, m_push, m_err;
    logic [RS-1:0] m_upd, m_pat;
    logic [IW-1:0] m_idx;
    ent_t          m_head;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, predict it, and check the combinational outputs.
    task automatic drive(input logic r, input logic lkv, input logic [31:0] pc,
                         input logic rv, input logic rt, input logic fl);
        rst = r; lk_valid = lkv; lk_pc = pc; res_valid = rv; res_taken = rt; flush = fl;
        m_idx  = pc[IW+1:2];
        m_pop  = !r && rv && (mq.size() > 0);
        m_push = !r && lkv && (mq.size() < QD) && !fl;
        m_err  = !r && rv && (mq.size() == 0);
        m_head = '0;
        m_upd  = '0;
        if (m_pop) begin
            m_head = mq[0];
            m_upd  = {mh[m_head.idx][RS-2:0], rt};
            sb.push_back('{addr: m_head.pat, tk: rt});
        end
        m_pat = (m_pop && m_head.idx == m_idx) ? m_upd : mh[m_idx];
        #1;
        if (!r) begin
            chk("lk_ready", 32'(lk_ready), 32'(mq.size() < QD));
            chk("lk_pattern", 32'(lk_pattern), 32'(m_pat));
        end
    endtask

    // Clock edge, advance the model, check registered outputs against model and scoreboard.
    task automatic tick();
        upd_t u;
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (mh[i]) mh[i] = '0;
            mq.delete();
            sb.delete();
            chk("rst_pht_en", 32'(pht_en), 32'd0);
            chk("rst_pht_addr", 32'(pht_addr), 32'd0);
            chk("rst_pht_pcbranch", 32'(pht_pcbranch), 32'd0);
            chk("rst_res_err", 32'(res_err), 32'd0);
            chk("rst_q_count", 32'(q_count), 32'd0);
        end else begin
            if (m_pop) begin
                mh[m_head.idx] = m_upd;
                void'(mq.pop_front());
            end
            if (m_push) mq.push_back('{idx: m_idx, pat: m_pat});
            if (flush) mq.delete();
            chk("pht_en", 32'(pht_en), 32'(m_pop));
            if (m_pop && sb.size() > 0) begin
                u = sb.pop_front();
                chk("pht_addr", 32'(pht_addr), 32'(u.addr));
                chk("pht_pcbranch", 32'(pht_pcbranch), 32'(u.tk));
            end
            chk("res_err", 32'(res_err), 32'(m_err));
            chk("q_count", 32'(q_count), 32'(mq.size()));
        end
    endtask

    initial begin
        logic [31:0] pc;

        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("reset_lk_ready", 32'(lk_ready), 32'd1);
        tick();

        // Single push and taken resolve on idx 4
        drive(0, 1, 32'h10, 0, 0, 0); tick();
        drive(0, 0, 32'h10, 1, 1, 0); tick();
        chk("one_pht_en", 32'(pht_en), 32'd1);
        chk("one_pht_addr", 32'(pht_addr), 32'd0);
        chk("one_pht_taken", 32'(pht_pcbranch), 32'd1);
        drive(0, 0, 32'h10, 0, 0, 0);
        chk("one_hist4", 32'(lk_pattern), 32'h1);
        tick();

        // Fill, reject a fifth, then drain T,T,N,T
        drive(1, 0, 0, 0, 0, 0); tick();
        repeat (4) begin drive(0, 1, 32'h10, 0, 0, 0); tick(); end
        chk("full_q_count", 32'(q_count), 32'd4);
        drive(0, 1, 32'h10, 0, 0, 0);
        chk("full_lk_ready", 32'(lk_ready), 32'd0);
        tick();
        chk("full_no_push", 32'(q_count), 32'd4);
        drive(0, 0, 32'h10, 1, 1, 0); tick();
        chk("drain_ready", 32'(lk_ready), 32'd1);
        drive(0, 0, 32'h10, 1, 1, 0); tick();
        drive(0, 0, 32'h10, 1, 0, 0); tick();
        drive(0, 0, 32'h10, 1, 1, 0); tick();
        chk("drain_last_addr", 32'(pht_addr), 32'd0);
        drive(0, 0, 32'h10, 0, 0, 0);
        chk("drain_hist4", 32'(lk_pattern), 32'h1);
        tick();

        // Same-cycle bypass into lookup and snapshot
        drive(0, 1, 32'h10, 0, 0, 0); tick();
        drive(0, 1, 32'h10, 1, 1, 0);
        chk("bypass_pattern", 32'(lk_pattern), 32'h3);
        tick();
        drive(0, 0, 32'h0, 1, 0, 0); tick();
        chk("bypass_snapshot", 32'(pht_addr), 32'h3);
        chk("bypass_dir", 32'(pht_pcbranch), 32'd0);

        // Resolve with empty queue
        drive(0, 0, 32'h10, 1, 1, 0); tick();
        chk("empty_err", 32'(res_err), 32'd1);
        chk("empty_pht_en", 32'(pht_en), 32'd0);
        drive(0, 0, 32'h10, 0, 0, 0);
        chk("empty_hist4", 32'(lk_pattern), 32'h2);
        tick();
        chk("empty_err_clear", 32'(res_err), 32'd0);

        // Randomized traffic across all indices with occasional flushes
        for (int i = 0; i < 300; i++) begin
            pc = $urandom;
            drive(0, ($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) == 0),
                  1'($urandom), ($urandom_range(0, 24) == 0));
            tick();
        end

        // Flush together with a taken resolve on a queue of three
        drive(1, 0, 0, 0, 0, 0); tick();
        repeat (3) begin drive(0, 1, 32'h08, 0, 0, 0); tick(); end
        drive(0, 1, 32'h08, 1, 1, 1); tick();
        chk("flush_pht_en", 32'(pht_en), 32'd1);
        chk("flush_q_count", 32'(q_count), 32'd0);
        drive(0, 0, 32'h08, 1, 0, 0); tick();
        chk("flush_no_more", 32'(pht_en), 32'd0);
        drive(0, 0, 32'h08, 0, 0, 0);
        chk("flush_hist2", 32'(lk_pattern), 32'h1);
        tick();

        // Reset mid-operation overrides everything
        drive(0, 1, 32'h1C, 0, 0, 0); tick();
        drive(0, 1, 32'h1C, 1, 1, 0); tick();
        drive(1, 1, 32'h1C, 1, 1, 1); tick();
        drive(0, 0, 32'h1C, 0, 0, 0);
        chk("midrst_hist7", 32'(lk_pattern), 32'h0);
        tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
